sub32_pipe: RTL and testbench



---
 rtl/sub32_pipe_pkg.sv | 10 +
 rtl/sub32_pipe_sub_half.sv | 14 +
 rtl/sub32_pipe.sv | 98 +++++++++
 tb/tb_sub32_pipe.sv | 114 +++++++++++
 4 files changed

// File: rtl/sub32_pipe_pkg.sv
// sub32_pipe_pkg: shared ALU constants (EFLAGS bit positions, default width)
package sub32_pipe_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int OF_BIT = 11;
endpackage

// File: rtl/sub32_pipe_sub_half.sv
// sub_half: W-bit subtract slice with borrow in/out and zero indicator
module sub_half #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic [W-1:0] d_o,
  output logic         bout_o,
  output logic         zero_o
);
  assign {bout_o, d_o} = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
  assign zero_o = d_o == '0;
endmodule

// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage pipelined subtractor with x86 flags, stall and flush
module sub32_pipe
  import sub32_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_borrow,
  input  logic             borrow_in,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic [WIDTH-1:0] diff,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             af,
  output logic             pf
);
  localparam int H = WIDTH / 2;
  logic         bin;
  logic [H-1:0] dlo_d, dlo_q, dhi_d, ahi_q, bhi_q;
  logic         blo_d, blo_q, zlo_d, zlo_q, af_d, af1_q, pf_d, pf1_q;
  logic         bhi_d, zhi_d, of_d;
  logic [4:0]   nib;
  logic         v1_q, v2_q, en1, en2;
  logic [WIDTH-1:0] diff_q;
  logic         cf_q, zf_q, sf_q, of_q, af_q, pf_q;
  assign bin = use_borrow & borrow_in;
  sub_half #(.W(H)) u_lo (
    .a_i(a[H-1:0]), .b_i(b[H-1:0]), .bin_i(bin),
    .d_o(dlo_d), .bout_o(blo_d), .zero_o(zlo_d)
  );
  assign nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, bin};
  assign af_d = nib[4];
  assign pf_d = ~^dlo_d[7:0];
  sub_half #(.W(H)) u_hi (
    .a_i(ahi_q), .b_i(bhi_q), .bin_i(blo_q),
    .d_o(dhi_d), .bout_o(bhi_d), .zero_o(zhi_d)
  );
  assign of_d = (ahi_q[H-1] != bhi_q[H-1]) && (dhi_d[H-1] != ahi_q[H-1]);
  assign en1 = !stall && valid_in;
  assign en2 = !stall && v1_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      dlo_q  <= '0;
      blo_q  <= 1'b0;
      zlo_q  <= 1'b0;
      af1_q  <= 1'b0;
      pf1_q  <= 1'b0;
      ahi_q  <= '0;
      bhi_q  <= '0;
      diff_q <= '0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
      sf_q   <= 1'b0;
      of_q   <= 1'b0;
      af_q   <= 1'b0;
      pf_q   <= 1'b0;
    end else begin
      v1_q <= !flush && (stall ? v1_q : valid_in);
      v2_q <= !flush && (stall ? v2_q : v1_q);
      if (en1) begin
        dlo_q <= dlo_d;
        blo_q <= blo_d;
        zlo_q <= zlo_d;
        af1_q <= af_d;
        pf1_q <= pf_d;
        ahi_q <= a[WIDTH-1:H];
        bhi_q <= b[WIDTH-1:H];
      end
      if (en2) begin
        diff_q <= {dhi_d, dlo_q};
        cf_q   <= bhi_d;
        zf_q   <= zlo_q && zhi_d;
        sf_q   <= dhi_d[H-1];
        of_q   <= of_d;
        af_q   <= af1_q;
        pf_q   <= pf1_q;
      end
    end
  end
  assign valid_out = v2_q;
  assign diff      = diff_q;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign af        = af_q;
  assign pf        = pf_q;
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: directed self-checking bench for sub32_pipe
module tb_sub32_pipe;
  logic        clk = 0, reset_n = 0, valid_in = 0, use_borrow = 0, borrow_in = 0;
  logic        stall = 0, flush = 0;
  logic [31:0] a = 0, b = 0, diff;
  logic        valid_out, cf, zf, sf, of, af, pf;
  int          errors = 0, checks = 0;
  sub32_pipe dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .a(a), .b(b),
    .use_borrow(use_borrow), .borrow_in(borrow_in), .stall(stall), .flush(flush),
    .valid_out(valid_out), .diff(diff), .cf(cf), .zf(zf), .sf(sf), .of(of),
    .af(af), .pf(pf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] ai, input logic [31:0] bi, input logic ub, input logic br);
    valid_in = 1; a = ai; b = bi; use_borrow = ub; borrow_in = br;
  endtask
  function automatic logic [31:0] flags();
    return {26'b0, cf, zf, sf, of, af, pf};
  endfunction
  task automatic expect_out(input string tag, input logic [31:0] d, input logic [5:0] f);
    check({tag, ".valid"}, {31'b0, valid_out}, 32'd1);
    check({tag, ".diff"}, diff, d);
    check({tag, ".flags"}, flags(), {26'b0, f});
  endtask
  task automatic run1(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                      input logic ub, input logic br, input logic [31:0] d, input logic [5:0] f);
    drive(ai, bi, ub, br);
    tick;
    valid_in = 0;
    tick;
    expect_out(tag, d, f);
    tick;
    check({tag, ".bubble"}, {31'b0, valid_out}, 32'd0);
  endtask
  // flag order below: {cf, zf, sf, of, af, pf}
  initial begin
    tick;
    tick;
    check("reset.valid", {31'b0, valid_out}, 32'd0);
    check("reset.diff", diff, 32'd0);
    check("reset.flags", flags(), 32'd0);
    reset_n = 1;
    run1("neg1", 32'h0, 32'h1, 0, 0, 32'hFFFFFFFF, 6'b101011);
    run1("ovf", 32'h80000000, 32'h1, 0, 0, 32'h7FFFFFFF, 6'b000111);
    run1("zero", 32'h5, 32'h5, 0, 0, 32'h0, 6'b010001);
    run1("sbb", 32'h10, 32'h0F, 1, 1, 32'h0, 6'b010011);
    run1("bin_ignored", 32'h5, 32'h5, 0, 1, 32'h0, 6'b010001);
    run1("posneg", 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h80000000, 6'b101101);
    drive(32'h00010000, 32'h1, 0, 0);
    tick;
    drive(32'h00010000, 32'h2, 0, 0);
    tick;
    expect_out("str1", 32'h0000FFFF, 6'b000011);
    drive(32'h00020000, 32'h1, 0, 0);
    stall = 1;
    tick;
    expect_out("stall1", 32'h0000FFFF, 6'b000011);
    tick;
    expect_out("stall2", 32'h0000FFFF, 6'b000011);
    stall = 0;
    tick;
    valid_in = 0;
    expect_out("str2", 32'h0000FFFE, 6'b000010);
    tick;
    expect_out("str3", 32'h0001FFFF, 6'b000011);
    tick;
    check("str.end", {31'b0, valid_out}, 32'd0);
    drive(32'h9, 32'h1, 0, 0);
    tick;
    drive(32'h9, 32'h2, 0, 0);
    tick;
    drive(32'h9, 32'h3, 0, 0);
    flush = 1;
    tick;
    flush = 0;
    valid_in = 0;
    check("flush.c1", {31'b0, valid_out}, 32'd0);
    tick;
    check("flush.c2", {31'b0, valid_out}, 32'd0);
    tick;
    check("flush.c3", {31'b0, valid_out}, 32'd0);
    run1("postflush", 32'h00000100, 32'h00000001, 0, 0, 32'h000000FF, 6'b000011);
    drive(32'h12345678, 32'h1, 0, 0);
    tick;
    drive(32'h12345678, 32'h2, 0, 0);
    tick;
    reset_n = 0;
    tick;
    check("rst.valid", {31'b0, valid_out}, 32'd0);
    check("rst.diff", diff, 32'd0);
    check("rst.flags", flags(), 32'd0);
    reset_n = 1;
    drive(32'h7, 32'h3, 0, 0);
    tick;
    valid_in = 0;
    check("rst.early", {31'b0, valid_out}, 32'd0);
    tick;
    expect_out("rst.op", 32'h4, 6'b000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
